// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, operation encodings and shifter modes.
// Imported by the ALU, its shifter and the datapath decoder.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        AluAnd  = 4'b0000,
        AluOr   = 4'b0001,
        AluAdd  = 4'b0010,
        AluXor  = 4'b0011,
        AluSll  = 4'b0100,
        AluSrl  = 4'b0101,
        AluSub  = 4'b0110,
        AluSra  = 4'b0111,
        AluSlt  = 4'b1000,
        AluSltu = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        ShSll = 2'b00,
        ShSrl = 2'b01,
        ShSra = 2'b10
    } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Five-stage barrel shifter for SLL/SRL/SRA. Left shifts reuse the right-shift
// network by bit-reversing the operand on the way in and the result on the way out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] Data1,
    input  logic [4:0]      shamt,
    input  shift_mode_t     mode,
    output logic [XLEN-1:0] result
);

    logic            fill;
    logic [XLEN-1:0] s0, s1, s2, s3, s4, s5;

    always_comb begin
        fill = (mode == ShSra) ? Data1[XLEN-1] : 1'b0;

        s0 = Data1;
        if (mode == ShSll) begin
            for (int i = 0; i < XLEN; i++) begin
                s0[i] = Data1[XLEN-1-i];
            end
        end

        s1 = shamt[0] ? {fill, s0[XLEN-1:1]}           : s0;
        s2 = shamt[1] ? {{2{fill}}, s1[XLEN-1:2]}      : s1;
        s3 = shamt[2] ? {{4{fill}}, s2[XLEN-1:4]}      : s2;
        s4 = shamt[3] ? {{8{fill}}, s3[XLEN-1:8]}      : s3;
        s5 = shamt[4] ? {{16{fill}}, s4[XLEN-1:16]}    : s4;

        result = s5;
        if (mode == ShSll) begin
            for (int i = 0; i < XLEN; i++) begin
                result[i] = s5[XLEN-1-i];
            end
        end
    end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result and BEQ/BNE equality flag, plus
// registered copies of both for debug/trace.
module rv32i_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      ALU_Operation,
    input  logic [XLEN-1:0] Data1,
    input  logic [XLEN-1:0] Data2,
    output logic [XLEN-1:0] ALU_result,
    output logic            ZERO,
    output logic [XLEN-1:0] ALU_result_q,
    output logic            ZERO_q
);

    logic [XLEN-1:0] shift_result;
    shift_mode_t     shift_mode;
    logic [XLEN-1:0] alu_result_d;
    logic            zero_d;

    always_comb begin
        shift_mode = ShSrl;
        if (ALU_Operation == AluSll) begin
            shift_mode = ShSll;
        end else if (ALU_Operation == AluSra) begin
            shift_mode = ShSra;
        end
    end

    alu_shifter #(
        .XLEN(XLEN)
    ) u_shifter (
        .Data1 (Data1),
        .shamt (Data2[4:0]),
        .mode  (shift_mode),
        .result(shift_result)
    );

    always_comb begin
        ALU_result = '0;
        case (ALU_Operation)
            AluAnd:  ALU_result = Data1 & Data2;
            AluOr:   ALU_result = Data1 | Data2;
            AluAdd:  ALU_result = Data1 + Data2;
            AluSub:  ALU_result = Data1 - Data2;
            AluXor:  ALU_result = Data1 ^ Data2;
            AluSll:  ALU_result = shift_result;
            AluSrl:  ALU_result = shift_result;
            AluSra:  ALU_result = shift_result;
            AluSlt:  ALU_result = {{(XLEN-1){1'b0}}, ($signed(Data1) < $signed(Data2))};
            AluSltu: ALU_result = {{(XLEN-1){1'b0}}, (Data1 < Data2)};
            default: ALU_result = '0;
        endcase
    end

    // Equality of the operands, independent of the selected operation.
    assign ZERO = (Data1 == Data2);

    always_comb begin
        alu_result_d = ALU_result;
        zero_d       = ZERO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_result_q <= '0;
            ZERO_q       <= 1'b0;
        end else begin
            ALU_result_q <= alu_result_d;
            ZERO_q       <= zero_d;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed cases, reset behaviour of the
// registered outputs, and seeded random vectors against an arithmetic model.
module tb_rv32i_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALU_Operation;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic [31:0] ALU_result;
    logic        ZERO;
    logic [31:0] ALU_result_q;
    logic        ZERO_q;

    int checks;
    int errors;

    rv32i_alu #(
        .XLEN(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALU_Operation(ALU_Operation),
        .Data1        (Data1),
        .Data2        (Data2),
        .ALU_result   (ALU_result),
        .ZERO         (ZERO),
        .ALU_result_q (ALU_result_q),
        .ZERO_q       (ZERO_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (op=%04b a=%08h b=%08h)",
                     tag, got, exp, ALU_Operation, Data1, Data2);
        end
    endtask

    // Reference computed with 64-bit integer arithmetic: shifts as multiply or
    // floor-divide by a power of two, comparisons on sign/zero-extended values.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     ua;
        longint     ub;
        longint     sa;
        longint     sb;
        longint     p;
        logic [63:0] t;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = longint'(1) << int'(b % 32);
        t  = '0;
        case (op)
            4'd0: t = {32'd0, a & b};
            4'd1: t = {32'd0, a | b};
            4'd2: t = ua + ub;
            4'd3: t = {32'd0, a ^ b};
            4'd4: t = ua * p;
            4'd5: t = ua / p;
            4'd6: t = ua - ub;
            4'd7: t = (sa >= 0) ? (sa / p) : -((-sa + p - 1) / p);
            4'd8: t = (sa < sb) ? 64'd1 : 64'd0;
            4'd9: t = (ua < ub) ? 64'd1 : 64'd0;
            default: t = '0;
        endcase
        return t[31:0];
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALU_Operation = op;
        Data1         = a;
        Data2         = b;
        #1;
    endtask

    task automatic directed(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res,
                            input logic exp_zero);
        apply(op, a, b);
        check_val({tag, ".res"}, ALU_result, exp_res);
        check_val({tag, ".zero"}, {31'd0, ZERO}, {31'd0, exp_zero});
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  basic_ops [4];
        int          seed;

        checks = 0;
        errors = 0;
        basic_ops[0] = 4'b0000;
        basic_ops[1] = 4'b0001;
        basic_ops[2] = 4'b0010;
        basic_ops[3] = 4'b0110;

        rst_n = 1'b0;
        apply(4'b0010, 32'd0, 32'd0);
        check_val("reset.res_q", ALU_result_q, 32'd0);
        check_val("reset.zero_q", {31'd0, ZERO_q}, 32'd0);

        directed("and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        directed("or",      4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
        directed("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        directed("sub_wrap", 4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        directed("sub_eq",  4'b0110, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);
        directed("and_eq5", 4'b0000, 32'd5, 32'd5, 32'd5, 1'b1);
        directed("xor",     4'b0011, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0);
        directed("sra_max", 4'b0111, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0);
        directed("srl_max", 4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
        directed("sll_hi",  4'b0100, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
        directed("sll_0",   4'b0100, 32'h89ABCDEF, 32'hFFFFFFE0, 32'h89ABCDEF, 1'b0);
        directed("sra_0",   4'b0111, 32'h89ABCDEF, 32'h00000020, 32'h89ABCDEF, 1'b0);
        directed("sra_pos", 4'b0111, 32'h40000000, 32'h00000004, 32'h04000000, 1'b0);
        directed("slt",     4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        directed("sltu",    4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        directed("slt_eq",  4'b1000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);

        // Equal operands: ZERO must be set for every code, legal or not.
        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            apply(op, 32'hDEADBEEF, 32'hDEADBEEF);
            check_val($sformatf("eq_all.zero%0d", i), {31'd0, ZERO}, 32'd1);
            check_val($sformatf("eq_all.res%0d", i), ALU_result,
                      ref_alu(op, 32'hDEADBEEF, 32'hDEADBEEF));
        end
        directed("eq_add",  4'b0010, 32'hDEADBEEF, 32'hDEADBEEF, 32'hBD5B7DDE, 1'b1);
        directed("neq_lsb", 4'b0000, 32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEE, 1'b0);
        directed("illegal", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0);

        // Registered outputs and asynchronous reset.
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0010, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        check_val("reg.res_q_eq", ALU_result_q, 32'd10);
        check_val("reg.zero_q_eq", {31'd0, ZERO_q}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst1.res_q", ALU_result_q, 32'd0);
        check_val("rst1.zero_q", {31'd0, ZERO_q}, 32'd0);
        check_val("rst1.res_live", ALU_result, 32'd10);
        check_val("rst1.zero_live", {31'd0, ZERO}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0010, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        check_val("reg.res_q_3", ALU_result_q, 32'd3);
        check_val("reg.zero_q_3", {31'd0, ZERO_q}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst2.res_q", ALU_result_q, 32'd0);
        check_val("rst2.res_live", ALU_result, 32'd3);
        @(posedge clk);
        #1;
        check_val("rst2.hold", ALU_result_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel.before_edge", ALU_result_q, 32'd0);
        @(posedge clk);
        #1;
        check_val("rel.after_edge", ALU_result_q, 32'd3);

        // Seeded random regression over the basic ops, then over every code.
        seed = 32'h1234_5678;
        void'($urandom(seed));
        for (int i = 0; i < 10000; i++) begin
            op = basic_ops[$urandom_range(3, 0)];
            a  = $urandom();
            b  = ($urandom_range(7, 0) == 0) ? a : $urandom();
            apply(op, a, b);
            check_val("rand.res", ALU_result, ref_alu(op, a, b));
            check_val("rand.zero", {31'd0, ZERO}, {31'd0, (a == b)});
        end
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = $urandom();
            b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom();
            apply(op, a, b);
            check_val("rand_all.res", ALU_result, ref_alu(op, a, b));
            check_val("rand_all.zero", {31'd0, ZERO}, {31'd0, (a == b)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
